game_state_controller: RTL and testbench

//  Top-level sequencer for the game loop: IDLE -> PLAY -> DYING -> OVER -> IDLE.

---
 rtl/game_state_controller.sv | 142 ++++++++++++++
 tb/tb_game_state_controller.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_state_controller.sv
// rtl/game_state_controller.sv - game loop sequencer IDLE->PLAY->DYING->OVER with collision/bounds detection
// Optional best-score register built only when HIGH_SCORE_EN is defined.
module game_state_controller #(
  parameter int DYING_FRAMES = 60,
  parameter int Y_MIN        = 30,
  parameter int Y_MAX        = 479,
  parameter int BLINK_FRAMES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       pix_bird,
  input  logic       pix_pipe,
  input  logic [9:0] bird_y,
  input  logic       btn_pressed,
  input  logic [6:0] score,
  output logic [1:0] state,
  output logic       reset_score,
  output logic       reset_physics,
  output logic       freeze,
  output logic       blink,
  output logic [6:0] high_score
);

  localparam int CW = $clog2(DYING_FRAMES + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PLAY  = 2'd1;
  localparam logic [1:0] S_DYING = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;

  localparam logic [CW-1:0] FCNT_LAST = CW'(DYING_FRAMES - 1);
  localparam logic [CW-1:0] BCNT_LAST = CW'(BLINK_FRAMES - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  logic [2:0]    btn_sync_q;
  logic          btn_edge_q;
  logic          hit_q, hit_d;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic [CW-1:0] bcnt_q, bcnt_d;
  logic          blink_q, blink_d;
  logic          oob;

  // Two synchroniser stages, a history stage, and a registered edge pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync_q <= '0;
      btn_edge_q <= 1'b0;
    end else begin
      btn_sync_q <= {btn_sync_q[1:0], btn_pressed};
      btn_edge_q <= btn_sync_q[1] & ~btn_sync_q[2];
    end
  end

  assign oob = (bird_y < 10'(Y_MIN)) | (bird_y > 10'(Y_MAX));

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    bcnt_d  = bcnt_q;
    blink_d = blink_q;
    hit_d   = hit_q;
    if (frame_start)
      hit_d = 1'b0;
    else if (state_q == S_PLAY && pix_bird && pix_pipe)
      hit_d = 1'b1;

    case (state_q)
      S_IDLE: if (btn_edge_q) state_d = S_PLAY;
      S_PLAY: if (frame_start && (hit_q || oob)) state_d = S_DYING;
      S_DYING: begin
        if (frame_start) begin
          if (fcnt_q == FCNT_LAST)
            state_d = S_OVER;
          else if (fcnt_q != CNT_MAX)
            fcnt_d = fcnt_q + 1'b1;
        end
      end
      default: begin
        if (btn_edge_q)
          state_d = S_IDLE;
        else if (frame_start) begin
          if (bcnt_q == BCNT_LAST) begin
            bcnt_d  = '0;
            blink_d = ~blink_q;
          end else if (bcnt_q != CNT_MAX) begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
    endcase

    // Counters sit at zero outside their state so each entry starts fresh.
    if (state_d != S_DYING) fcnt_d = '0;
    if (state_d != S_OVER) begin
      bcnt_d  = '0;
      blink_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hit_q   <= 1'b0;
      fcnt_q  <= '0;
      bcnt_q  <= '0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      fcnt_q  <= fcnt_d;
      bcnt_q  <= bcnt_d;
      blink_q <= blink_d;
    end
  end

  assign state         = state_q;
  assign reset_score   = (state_q == S_IDLE);
  assign reset_physics = (state_q == S_IDLE) | (state_q == S_OVER);
  assign freeze        = (state_q == S_DYING) | (state_q == S_OVER);
  assign blink         = blink_q;

`ifdef HIGH_SCORE_EN
  logic [6:0] high_score_q;

  // Score is sampled on the crash cycle itself, before freeze reaches the generator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      high_score_q <= '0;
    else if (state_q == S_PLAY && state_d == S_DYING && score > high_score_q)
      high_score_q <= score;
  end

  assign high_score = high_score_q;
`else
  logic unused_score;
  assign unused_score = ^score;
  assign high_score   = 7'd0;
`endif

endmodule

// File: tb/tb_game_state_controller.sv
// tb/tb_game_state_controller.sv - randomized bench for game_state_controller against a frame-level model
`timescale 1ns/1ps
module tb_game_state_controller;

  localparam int DYING_FRAMES = 60;
  localparam int BLINK_FRAMES = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       pix_bird = 1'b0;
  logic       pix_pipe = 1'b0;
  logic [9:0] bird_y = 10'd200;
  logic       btn_pressed = 1'b0;
  logic [6:0] score = 7'd0;
  logic [1:0] state;
  logic       reset_score, reset_physics, freeze, blink;
  logic [6:0] high_score;

  int checks = 0;
  int errors = 0;
  int pos = 0;
  int flen = 12;
  int coll_pm = 0;
  bit y_rand = 1'b0;
  bit sc_rand = 1'b1;
  logic [9:0] yv = 10'd200;
  logic [6:0] sv = 7'd0;
  int exp_hs12;

  always #5 clk = ~clk;

  game_state_controller dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_bird(pix_bird),
    .pix_pipe(pix_pipe), .bird_y(bird_y), .btn_pressed(btn_pressed), .score(score),
    .state(state), .reset_score(reset_score), .reset_physics(reset_physics),
    .freeze(freeze), .blink(blink), .high_score(high_score)
  );

  // Reference: game mode, frames seen since entering the mode, best score,
  // and the raw button samples (an edge acts three samples after it is seen).
  typedef struct packed {
    logic [1:0]  mode;
    logic        hit;
    logic [15:0] frames;
    logic [6:0]  hs;
    logic [3:0]  bh;
  } m_t;

  m_t m = '0;

  function automatic m_t model_next(input m_t c, input logic fs, input logic pb, input logic pp,
                                    input logic [9:0] by, input logic [6:0] sc, input logic btn);
    m_t n;
    logic bedge;
    logic crash;
    n = c;
    bedge = c.bh[2] & ~c.bh[3];
    crash = fs && (c.hit || by < 10'd30 || by > 10'd479);
    n.bh = {c.bh[2:0], btn};
    n.hit = fs ? 1'b0 : (c.hit | (c.mode == 2'd1 && pb && pp));
    case (c.mode)
      2'd0: if (bedge) n.mode = 2'd1;
      2'd1: if (crash) begin
        n.mode = 2'd2;
        n.frames = '0;
`ifdef HIGH_SCORE_EN
        if (sc > c.hs) n.hs = sc;
`endif
      end
      2'd2: if (fs) begin
        n.frames = c.frames + 1;
        if (n.frames == DYING_FRAMES) begin
          n.mode = 2'd3;
          n.frames = '0;
        end
      end
      default: begin
        if (bedge) begin
          n.mode = 2'd0;
          n.frames = '0;
        end else if (fs) begin
          n.frames = c.frames + 1;
        end
      end
    endcase
`ifndef HIGH_SCORE_EN
    if (sc == 7'h7f) n.hs = '0;
`endif
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else m <= model_next(m, frame_start, pix_bird, pix_pipe, bird_y, score, btn_pressed);
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare();
    check_eq("state", int'(state), int'(m.mode));
    check_eq("reset_score", int'(reset_score), int'(m.mode == 2'd0));
    check_eq("reset_physics", int'(reset_physics), int'(m.mode == 2'd0 || m.mode == 2'd3));
    check_eq("freeze", int'(freeze), int'(m.mode >= 2'd2));
    check_eq("blink", int'(blink), (m.mode == 2'd3) ? (int'(m.frames) / BLINK_FRAMES) % 2 : 0);
    check_eq("high_score", int'(high_score), int'(m.hs));
  endtask

  function automatic logic [9:0] rand_y();
    if ($urandom_range(99) < 4) begin
      case ($urandom_range(5))
        0: return 10'd0;
        1: return 10'd20;
        2: return 10'd29;
        3: return 10'd480;
        4: return 10'd600;
        default: return 10'd1023;
      endcase
    end
    return 10'($urandom_range(479, 30));
  endfunction

  task automatic step();
    int r;
    @(negedge clk);
    compare();
    frame_start = (pos == 0);
    if (pos == 0) begin
      flen   = $urandom_range(10, 18);
      bird_y = y_rand ? rand_y() : yv;
      score  = sc_rand ? 7'($urandom_range(126)) : sv;
    end
    r = $urandom_range(999);
    pix_bird = (r < coll_pm) || (r >= 500 && r < 700);
    pix_pipe = (r < coll_pm) || (r >= 700 && r < 900);
    pos = (pos + 1 >= flen) ? 0 : pos + 1;
  endtask

  task automatic wait_fs();
    do step(); while (!frame_start);
  endtask

  task automatic press();
    btn_pressed = 1'b1;
    repeat (5) step();
    btn_pressed = 1'b0;
    repeat (5) step();
  endtask

  initial begin
`ifdef HIGH_SCORE_EN
    exp_hs12 = 12;
`else
    exp_hs12 = 0;
`endif
    repeat (3) step();
    check_eq("reset_state", int'(state), 0);
    rst_n = 1'b1;
    repeat (5) wait_fs();
    check_eq("idle_hold", int'(state), 0);

    btn_pressed = 1'b1;
    repeat (4) step();
    check_eq("play_entry", int'(state), 1);
    repeat (1000) step();
    check_eq("play_hold", int'(state), 1);
    btn_pressed = 1'b0;

    wait_fs();
    repeat (3) step();
    pix_bird = 1'b1;
    pix_pipe = 1'b1;
    wait_fs();
    step();
    check_eq("dying_after_hit", int'(state), 2);
    check_eq("freeze_after_hit", int'(freeze), 1);
    for (int f = 0; f < DYING_FRAMES; f++) begin
      if (f == 10) btn_pressed = 1'b1;
      if (f == 20) btn_pressed = 1'b0;
      wait_fs();
    end
    step();
    check_eq("over_after_frames", int'(state), 3);
    repeat (BLINK_FRAMES) wait_fs();
    step();
    check_eq("blink_first_toggle", int'(blink), 1);
    repeat (20) wait_fs();
    press();
    check_eq("over_to_idle", int'(state), 0);
    check_eq("blink_idle", int'(blink), 0);

    press();
    yv = 10'd30;
    repeat (3) wait_fs();
    step();
    check_eq("y30_stay", int'(state), 1);
    yv = 10'd479;
    repeat (3) wait_fs();
    step();
    check_eq("y479_stay", int'(state), 1);
    sc_rand = 1'b0;
    sv = 7'd12;
    yv = 10'd20;
    wait_fs();
    step();
    check_eq("y20_dying", int'(state), 2);
    check_eq("hs_after_12", int'(high_score), exp_hs12);

    yv = 10'd200;
    repeat (DYING_FRAMES) wait_fs();
    step();
    press();
    press();
    check_eq("replay", int'(state), 1);
    sv = 7'd7;
    yv = 10'd480;
    wait_fs();
    step();
    check_eq("y480_dying", int'(state), 2);
    check_eq("hs_after_7", int'(high_score), exp_hs12);
    yv = 10'd200;
    repeat (7) step();
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_state", int'(state), 0);
    check_eq("async_rst_hs", int'(high_score), 0);
    check_eq("async_rst_freeze", int'(freeze), 0);
    @(negedge clk);
    rst_n = 1'b1;

    sc_rand = 1'b1;
    y_rand  = 1'b1;
    coll_pm = 3;
    for (int i = 0; i < 400; i++) begin
      btn_pressed = 1'($urandom_range(1));
      repeat ($urandom_range(1, 30)) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
